// File: rtl/btn_cond_pkg.sv
// Shared definitions for the pushbutton conditioner: channel FSM encoding,
// default timing constants and the stopwatch button channel indices.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Defaults assume the 100 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEF = 200000;
  localparam int REPEAT_DELAY_DEF    = 50000000;
  localparam int REPEAT_PERIOD_DEF   = 10000000;
  localparam logic [2:0] REPEAT_MASK_DEF = 3'b100;

  localparam int BTN_START_STOP = 0;
  localparam int BTN_SET        = 1;
  localparam int BTN_CHANGE     = 2;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with saturating
// counter, and (with BUTTON_CONDITIONER_AUTOREPEAT_EN) a hold-repeat counter.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN     = 1'b0
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_meta;
  logic             sync_q;
  btn_state_e       state;
  btn_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_q;
  logic             press_nxt;
  logic             release_q;
  logic             release_nxt;
  logic             rep_fire;

  // Preset to 1 so a button held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= btn_n;
      sync_q    <= sync_meta;
    end
  end

  assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RELEASED;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_q   <= press_nxt | rep_fire;
      release_q <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (!sync_q) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (sync_q) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_DONE) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (sync_q) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!sync_q) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_DONE) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    level         = (state == PRESSED) || (state == RELEASE_WAIT);
    press_pulse   = press_q;
    release_pulse = release_q;
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_V = REP_W'(REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_nxt;
  logic [REP_W-1:0] rep_inc;
  logic             rep_armed;
  logic             rep_armed_nxt;

  assign rep_inc = rep_cnt + REP_W'(1);

  // Counter only advances while the held level is stable; any exit from
  // PRESSED (even a bounce into RELEASE_WAIT) restarts the initial delay.
  always_comb begin
    rep_cnt_nxt   = '0;
    rep_armed_nxt = 1'b0;
    rep_fire      = 1'b0;
    if (REPEAT_EN && (state == PRESSED) && !sync_q) begin
      rep_armed_nxt = rep_armed;
      rep_cnt_nxt   = rep_inc;
      if (rep_inc == (rep_armed ? REP_PERIOD_V : REP_DELAY_V)) begin
        rep_fire      = 1'b1;
        rep_cnt_nxt   = '0;
        rep_armed_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_armed <= rep_armed_nxt;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch pushbutton front end: N_BTN independent debounced channels.
// Define BUTTON_CONDITIONER_AUTOREPEAT_EN to enable hold auto-repeat.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY              = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD             = REPEAT_PERIOD_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(REPEAT_MASK_DEF)
`endif
) (
  input  logic             clk100_i,
  input  logic             rstn_i,
  input  logic [N_BTN-1:0] btn_n_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
`endif
    ) u_ch (
      .clk          (clk100_i),
      .rstn         (rstn_i),
      .btn_n        (btn_n_i[i]),
      .level        (btn_level_o[i]),
      .press_pulse  (btn_press_o[i]),
      .release_pulse(btn_release_o[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES = 4;
// repeat expectations follow BUTTON_CONDITIONER_AUTOREPEAT_EN.
module tb_button_conditioner;
  import btn_cond_pkg::*;

  localparam int N_BTN = 3;
  localparam int DB    = 4;

  logic             clk100_i = 1'b0;
  logic             rstn_i;
  logic [N_BTN-1:0] btn_n_i;
  logic [N_BTN-1:0] btn_level_o;
  logic [N_BTN-1:0] btn_press_o;
  logic [N_BTN-1:0] btn_release_o;

  int checks = 0;
  int errors = 0;
  int press_cnt[N_BTN];
  int release_cnt[N_BTN];

  button_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DB)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .REPEAT_MASK    (3'b100)
`endif
  ) dut (
    .clk100_i     (clk100_i),
    .rstn_i       (rstn_i),
    .btn_n_i      (btn_n_i),
    .btn_level_o  (btn_level_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o)
  );

  always #5 clk100_i = ~clk100_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N_BTN-1:0] btn_n_val);
    btn_n_i = btn_n_val;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < N_BTN; i++) begin
      press_cnt[i]   = 0;
      release_cnt[i] = 0;
    end
  endtask

  // Advance past one rising edge and settle mid-cycle, tallying pulses.
  task automatic nextEdge();
    @(posedge clk100_i);
    @(negedge clk100_i);
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_press_o[i] === 1'b1) press_cnt[i]++;
      if (btn_release_o[i] === 1'b1) release_cnt[i]++;
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) nextEdge();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_rep;
    int exp_ch2;
    rstn_i = 1'b0;
    applyStimulus(3'b110);
    clearCounts();

    // Start/stop held through reset.
    waitEdges(3);
    checkOutput("reset level", 32'(btn_level_o), 32'h0);
    checkOutput("reset press", 32'(btn_press_o), 32'h0);
    checkOutput("reset release", 32'(btn_release_o), 32'h0);
    rstn_i = 1'b1;
    clearCounts();
    waitEdges(5);
    checkOutput("held-reset press early", 32'(btn_press_o), 32'h0);
    waitEdges(1);
    checkOutput("held-reset press edge6", 32'(btn_press_o), 32'h1);
    checkOutput("held-reset level", 32'(btn_level_o), 32'h1);
    waitEdges(1);
    checkOutput("held-reset press one-shot", 32'(btn_press_o), 32'h0);
    applyStimulus(3'b111);
    waitEdges(5);
    checkOutput("ch0 release early", 32'(btn_release_o), 32'h0);
    waitEdges(1);
    checkOutput("ch0 release pulse", 32'(btn_release_o), 32'h1);
    checkOutput("ch0 level after release", 32'(btn_level_o), 32'h0);
    waitEdges(3);
    checkOutput("ch0 press count", 32'(press_cnt[BTN_START_STOP]), 32'd1);
    checkOutput("ch0 release count", 32'(release_cnt[BTN_START_STOP]), 32'd1);

    // Clean press on the set button, held 20 cycles.
    clearCounts();
    applyStimulus(3'b101);
    waitEdges(5);
    checkOutput("ch1 press early", 32'(btn_press_o), 32'h0);
    waitEdges(1);
    checkOutput("ch1 press pulse", 32'(btn_press_o), 32'h2);
    checkOutput("ch1 level", 32'(btn_level_o), 32'h2);
    waitEdges(14);
    applyStimulus(3'b111);
    waitEdges(5);
    checkOutput("ch1 level still held", 32'(btn_level_o), 32'h2);
    checkOutput("ch1 release early", 32'(btn_release_o), 32'h0);
    waitEdges(1);
    checkOutput("ch1 release pulse", 32'(btn_release_o), 32'h2);
    checkOutput("ch1 level released", 32'(btn_level_o), 32'h0);
    waitEdges(4);
    checkOutput("ch1 press count", 32'(press_cnt[BTN_SET]), 32'd1);
    checkOutput("ch1 release count", 32'(release_cnt[BTN_SET]), 32'd1);

    // Change button bouncing in 3-cycle segments, then held.
    clearCounts();
    for (int seg = 0; seg < 10; seg++) begin
      applyStimulus((seg % 2 == 0) ? 3'b011 : 3'b111);
      waitEdges(3);
    end
    applyStimulus(3'b011);
    waitEdges(5);
    checkOutput("bounce no press", 32'(press_cnt[BTN_CHANGE]), 32'd0);
    checkOutput("bounce no release", 32'(release_cnt[BTN_CHANGE]), 32'd0);
    checkOutput("bounce level low", 32'(btn_level_o), 32'h0);
    waitEdges(1);
    checkOutput("bounce settled press", 32'(btn_press_o), 32'h4);
    applyStimulus(3'b111);
    waitEdges(8);
    checkOutput("bounce total presses", 32'(press_cnt[BTN_CHANGE]), 32'd1);
    checkOutput("bounce total releases", 32'(release_cnt[BTN_CHANGE]), 32'd1);

    // Simultaneous start/stop + change press, held for repeat observation.
    clearCounts();
    applyStimulus(3'b010);
    waitEdges(5);
    checkOutput("dual press early", 32'(btn_press_o), 32'h0);
    waitEdges(1);
    checkOutput("dual press coincide", 32'(btn_press_o), 32'h5);
    checkOutput("dual level", 32'(btn_level_o), 32'h5);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    exp_rep = 1;
`else
    exp_rep = 0;
`endif
    for (int j = 1; j <= 30; j++) begin
      nextEdge();
      exp_ch2 = (exp_rep == 1 && j >= 10 && (j % 5 == 0)) ? 32'h4 : 32'h0;
      checkOutput($sformatf("hold press j=%0d", j), 32'(btn_press_o), 32'(exp_ch2));
    end
    checkOutput("hold level", 32'(btn_level_o), 32'h5);
    applyStimulus(3'b111);
    waitEdges(8);
    checkOutput("hold ch0 presses", 32'(press_cnt[BTN_START_STOP]), 32'd1);
    checkOutput("hold ch1 presses", 32'(press_cnt[BTN_SET]), 32'd0);
    checkOutput("hold ch2 presses", 32'(press_cnt[BTN_CHANGE]), (exp_rep == 1) ? 32'd6 : 32'd1);
    checkOutput("hold releases ch0", 32'(release_cnt[BTN_START_STOP]), 32'd1);
    checkOutput("hold releases ch2", 32'(release_cnt[BTN_CHANGE]), 32'd1);

    // Async reset while ch1 debounces at count 3 and ch0 is pressed.
    clearCounts();
    applyStimulus(3'b110);
    waitEdges(6);
    checkOutput("pre-reset ch0 level", 32'(btn_level_o), 32'h1);
    applyStimulus(3'b100);
    waitEdges(5);
    rstn_i = 1'b0;
    #1;
    checkOutput("async reset level", 32'(btn_level_o), 32'h0);
    checkOutput("async reset press", 32'(btn_press_o), 32'h0);
    checkOutput("async reset release", 32'(btn_release_o), 32'h0);
    applyStimulus(3'b111);
    waitEdges(3);
    rstn_i = 1'b1;
    waitEdges(8);
    checkOutput("post-reset ch1 presses", 32'(press_cnt[BTN_SET]), 32'd0);
    checkOutput("post-reset releases", 32'(release_cnt[BTN_START_STOP] + release_cnt[BTN_SET]), 32'd0);
    checkOutput("post-reset level", 32'(btn_level_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
